// File: rtl/p16_fp32_conv_arb.sv
// p16_fp32_conv_arb: shares one combinational posit16 (es=1) to fp32 converter between NREQ
// requesters. It uses round-robin arbitration and a two-stage valid/ready pipeline.
//   S1 holds the granted posit and its requester id.
//   S2 holds the fp32 result and its id, and drives rsp_*.
// The controller handles zero and NaR, because the datapath does not cover them.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_data  per-requester request (16-bit posit per requester)
//   req_ready           per-requester accept (one-hot or zero)
//   rsp_valid/ready     result handshake; rsp_data = fp32, rsp_id = owning requester
//   busy                either pipeline stage holds data
// Optional (macro P16_CONV_STATS_EN):
//   stat_conv           saturating count of response handshakes
//   stat_nar            saturating count of handshaked results that came from NaR
module p16_fp32_conv_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
`ifdef P16_CONV_STATS_EN
  ,
  output logic [15:0]          stat_conv,
  output logic [15:0]          stat_nar
`endif
);

  logic            s1_vld_q, s1_vld_d;
  logic [15:0]     s1_data_q, s1_data_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_vld_q, s2_vld_d;
  logic [31:0]     s2_data_q, s2_data_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            s2_adv, s1_load, hs, rsp_hs;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [15:0]     gnt_data;
  int unsigned     idx;

  // Pipeline advance
  always_comb begin
    s2_adv  = s1_vld_q && (!s2_vld_q || rsp_ready);
    s1_load = !s1_vld_q || s2_adv;
    rsp_hs  = s2_vld_q && rsp_ready;
  end

  // Round-robin search starting at ptr_q, wrapping modulo NREQ
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) gnt_data = req_data[16*i +: 16];
    end
  end

  always_comb begin
    hs = gnt_any && s1_load;
    // rst gating keeps req_ready low for the whole reset, not only after an edge
    req_ready = (hs && !rst) ? (NREQ'(1) << gnt_idx) : '0;
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  // Posit16 (es=1) decode of the S1 operand
  logic [15:0] mag;
  logic [4:0]  run;
  logic        stop;
  logic [14:0] tail;
  logic [7:0]  exp8;
  logic        p_zero, p_nar;
  logic [31:0] conv;

  always_comb begin
    p_zero = (s1_data_q == 16'h0000);
    p_nar  = (s1_data_q == 16'h8000);
    mag    = s1_data_q[15] ? (~s1_data_q + 16'd1) : s1_data_q;
    run    = 5'd0;
    stop   = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (!stop && (mag[i] == mag[14])) run = run + 5'd1;
      else stop = 1'b1;
    end
    // Drop regime and terminator: tail[14] is the exponent bit, tail[13:0] the fraction.
    // A full-length regime shifts everything out, giving e=0 and an empty fraction.
    tail = mag[14:0] << (run + 5'd1);
    if (mag[14]) exp8 = 8'd125 + {2'b00, run, 1'b0} + {7'd0, tail[14]};  // k = run-1
    else         exp8 = 8'd127 - {2'b00, run, 1'b0} + {7'd0, tail[14]};  // k = -run
    if (p_zero)     conv = 32'h0000_0000;
    else if (p_nar) conv = 32'h7FC0_0000;
    else            conv = {s1_data_q[15], exp8, tail[13:0], 9'd0};
  end

  always_comb begin
    s1_vld_d  = s1_load ? hs : s1_vld_q;
    s1_data_d = (s1_load && hs) ? gnt_data : s1_data_q;
    s1_id_d   = (s1_load && hs) ? gnt_idx : s1_id_q;
    s2_vld_d  = s2_adv ? 1'b1 : (rsp_hs ? 1'b0 : s2_vld_q);
    s2_data_d = s2_adv ? conv : s2_data_q;
    s2_id_d   = s2_adv ? s1_id_q : s2_id_q;
  end

`ifdef P16_CONV_STATS_EN
  logic        s2_nar_q, s2_nar_d;
  logic [15:0] stat_conv_q, stat_conv_d;
  logic [15:0] stat_nar_q, stat_nar_d;

  always_comb begin
    s2_nar_d    = s2_adv ? p_nar : s2_nar_q;
    stat_conv_d = stat_conv_q;
    stat_nar_d  = stat_nar_q;
    if (rsp_hs && (stat_conv_q != 16'hFFFF)) stat_conv_d = stat_conv_q + 16'd1;
    if (rsp_hs && s2_nar_q && (stat_nar_q != 16'hFFFF)) stat_nar_d = stat_nar_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_nar_q    <= 1'b0;
      stat_conv_q <= '0;
      stat_nar_q  <= '0;
    end else begin
      s2_nar_q    <= s2_nar_d;
      stat_conv_q <= stat_conv_d;
      stat_nar_q  <= stat_nar_d;
    end
  end

  assign stat_conv = stat_conv_q;
  assign stat_nar  = stat_nar_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_id_q   <= '0;
      ptr_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_id_q   <= s1_id_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    rsp_valid = s2_vld_q;
    rsp_data  = s2_data_q;
    rsp_id    = s2_id_q;
    busy      = s1_vld_q || s2_vld_q;
  end

endmodule
